// File: rtl/fp_issue_pkg.sv
// ============================================================================
// Module      : fp_issue_pkg
// Description : Shared types, opcodes, rounding modes and latency lookup for
//               the FP issue sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    localparam logic [4:0] FP_ADD    = 5'd0;
    localparam logic [4:0] FP_SUB    = 5'd1;
    localparam logic [4:0] FP_MUL    = 5'd2;
    localparam logic [4:0] FP_DIV    = 5'd3;
    localparam logic [4:0] FP_SQRT   = 5'd4;
    localparam logic [4:0] FP_FMADD  = 5'd5;
    localparam logic [4:0] FP_FMSUB  = 5'd6;
    localparam logic [4:0] FP_FNMSUB = 5'd7;
    localparam logic [4:0] FP_FNMADD = 5'd8;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;
    localparam logic [2:0] DYN = 3'b111;

    // Opcodes above the fused group all fall into the single-cycle misc class.
    function automatic int op_latency(
        input logic [4:0] op,
        input int         lat_add,
        input int         lat_mul,
        input int         lat_fma,
        input int         lat_div,
        input int         lat_sqrt,
        input int         lat_misc
    );
        int lat;
        if (op <= FP_SUB)
            lat = lat_add;
        else if (op == FP_MUL)
            lat = lat_mul;
        else if (op == FP_DIV)
            lat = lat_div;
        else if (op == FP_SQRT)
            lat = lat_sqrt;
        else if ((op >= FP_FMADD) && (op <= FP_FNMADD))
            lat = lat_fma;
        else
            lat = lat_misc;
        return lat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_rm_resolve.sv
// ============================================================================
// Module      : fp_rm_resolve
// Description : Resolves the dynamic rounding mode against frm and flags the
//               reserved encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_rm_resolve
    import fp_issue_pkg::*;
(
    input  logic [2:0] req_rm,
    input  logic [2:0] frm,
    output logic [2:0] eff_rm,
    output logic       illegal
);

    assign eff_rm  = (req_rm == DYN) ? frm : req_rm;
    // 101, 110 and 111 are reserved once DYN has been substituted.
    assign illegal = (eff_rm > RMM);

endmodule

`default_nettype wire

// File: rtl/fp_issue_sequencer.sv
// ============================================================================
// Module      : fp_issue_sequencer
// Description : Issues one FP operation at a time into the shared FP ALU,
//               times its latency window and returns the result to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_issue_sequencer
    import fp_issue_pkg::*;
#(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 3,
    parameter int LAT_FMA  = 4,
    parameter int LAT_DIV  = 10,
    parameter int LAT_SQRT = 12,
    parameter int LAT_MISC = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [31:0] req_c,
    input  logic [2:0]  frm,
    input  logic        flush,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_c,
    output logic [4:0]  alu_ctrl,
    output logic [2:0]  alu_rm,
    output logic        alu_enable,
    input  logic [31:0] alu_result,
    input  logic [4:0]  alu_fflags,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_rd,
    output logic [4:0]  rsp_fflags,
    output logic        rsp_illegal,

    output logic [4:0]  fflags_acc,
    input  logic        fflags_clr,
    output logic        busy
);

    if ((LAT_ADD  < 1) || (LAT_ADD  > 16) ||
        (LAT_MUL  < 1) || (LAT_MUL  > 16) ||
        (LAT_FMA  < 1) || (LAT_FMA  > 16) ||
        (LAT_DIV  < 1) || (LAT_DIV  > 16) ||
        (LAT_SQRT < 1) || (LAT_SQRT > 16) ||
        (LAT_MISC < 1) || (LAT_MISC > 16)) begin : g_lat_range_check
        $error("fp_issue_sequencer: every LAT_* parameter must lie in 1..16");
    end

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic [31:0]        r_alu_c;
    logic [4:0]         r_alu_ctrl;
    logic [2:0]         r_alu_rm;
    logic               r_alu_enable;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_result;
    logic [4:0]         r_rsp_rd;
    logic [4:0]         r_rsp_fflags;
    logic               r_rsp_illegal;
    logic [4:0]         r_fflags_acc;

    logic [2:0]         w_eff_rm;
    logic               w_rm_illegal;
    logic [CNT_W-1:0]   w_cnt_load;
    logic               w_rsp_hs;

    fp_rm_resolve u_rm_resolve (
        .req_rm  (req_rm),
        .frm     (frm),
        .eff_rm  (w_eff_rm),
        .illegal (w_rm_illegal)
    );

    assign w_cnt_load = CNT_W'(op_latency(req_op, LAT_ADD, LAT_MUL, LAT_FMA,
                                          LAT_DIV, LAT_SQRT, LAT_MISC) - 1);

    // A handshake coinciding with flush is discarded, so it never reaches the accumulator.
    assign w_rsp_hs  = r_rsp_valid && rsp_ready && !flush;
    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_c       <= '0;
            r_alu_ctrl    <= '0;
            r_alu_rm      <= '0;
            r_alu_enable  <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_rd      <= '0;
            r_rsp_fflags  <= '0;
            r_rsp_illegal <= 1'b0;
            r_fflags_acc  <= '0;
        end else begin
            r_fflags_acc <= (fflags_clr ? 5'd0 : r_fflags_acc) |
                            (w_rsp_hs ? r_rsp_fflags : 5'd0);

            if (flush) begin
                r_state      <= ST_IDLE;
                r_alu_enable <= 1'b0;
                r_rsp_valid  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (req_valid) begin
                            r_rsp_rd <= req_rd;
                            if (w_rm_illegal) begin
                                r_rsp_result  <= '0;
                                r_rsp_fflags  <= '0;
                                r_rsp_illegal <= 1'b1;
                                r_rsp_valid   <= 1'b1;
                                r_state       <= ST_DONE;
                            end else begin
                                r_alu_a      <= req_a;
                                r_alu_b      <= req_b;
                                r_alu_c      <= req_c;
                                r_alu_ctrl   <= req_op;
                                r_alu_rm     <= w_eff_rm;
                                r_cnt        <= w_cnt_load;
                                r_alu_enable <= 1'b1;
                                r_state      <= ST_EXEC;
                            end
                        end
                    end
                    ST_EXEC: begin
                        if (r_cnt == '0) begin
                            r_rsp_result  <= alu_result;
                            r_rsp_fflags  <= alu_fflags;
                            r_rsp_illegal <= 1'b0;
                            r_alu_enable  <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (rsp_ready) begin
                            r_rsp_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_alu_enable <= 1'b0;
                        r_rsp_valid  <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_c       = r_alu_c;
    assign alu_ctrl    = r_alu_ctrl;
    assign alu_rm      = r_alu_rm;
    assign alu_enable  = r_alu_enable;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_rd      = r_rsp_rd;
    assign rsp_fflags  = r_rsp_fflags;
    assign rsp_illegal = r_rsp_illegal;
    assign fflags_acc  = r_fflags_acc;

endmodule

`default_nettype wire

// File: tb/tb_fp_issue_sequencer.sv
// ============================================================================
// Module      : tb_fp_issue_sequencer
// Description : Self-checking bench: vector table, hand-written flush/reset
//               sequences and randomized ops against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_issue_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic [2:0]  req_rm = '0;
    logic [4:0]  req_rd = '0;
    logic [31:0] req_a = '0, req_b = '0, req_c = '0;
    logic [2:0]  frm = '0;
    logic        flush = 1'b0;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [4:0]  alu_ctrl;
    logic [2:0]  alu_rm;
    logic        alu_enable;
    logic [31:0] alu_result;
    logic [4:0]  alu_fflags;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_rd, rsp_fflags;
    logic        rsp_illegal;
    logic [4:0]  fflags_acc;
    logic        fflags_clr = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    fp_issue_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rm(req_rm), .req_rd(req_rd), .req_a(req_a), .req_b(req_b),
        .req_c(req_c), .frm(frm), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_ctrl(alu_ctrl),
        .alu_rm(alu_rm), .alu_enable(alu_enable), .alu_result(alu_result),
        .alu_fflags(alu_fflags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_rd(rsp_rd), .rsp_fflags(rsp_fflags), .rsp_illegal(rsp_illegal),
        .fflags_acc(fflags_acc), .fflags_clr(fflags_clr), .busy(busy)
    );

    // ALU stand-in: the true result appears only in the last cycle of the expected window.
    int          en_cnt = 0;
    int          tb_lat = 0;
    logic [31:0] good_res = '0;
    logic [4:0]  good_fl = '0;
    always @(posedge clk) en_cnt <= alu_enable ? en_cnt + 1 : 0;
    assign alu_result = (alu_enable && en_cnt == tb_lat - 1) ? good_res : ~good_res;
    assign alu_fflags = (alu_enable && en_cnt == tb_lat - 1) ? good_fl : ~good_fl;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rm;
        logic [2:0]  frm_v;
        logic [4:0]  rd;
        logic [31:0] a, b, c, res;
        logic [4:0]  fl;
        int          hold;
        logic        clr;
        int          exp_lat;
        logic        exp_ill;
        logic [2:0]  exp_rm;
        logic [4:0]  exp_acc;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] m_a = '0, m_b = '0, m_c = '0;
    logic [4:0]  m_ctrl = '0;
    logic [2:0]  m_rm = '0;
    logic [4:0]  acc_model = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %h required %h", nm, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [2:0] rm, input logic [2:0] fv,
                                input logic [4:0] rd, input logic [31:0] a, input logic [31:0] res,
                                input logic [4:0] fl, input int hold, input logic clr,
                                input int elat, input logic eill, input logic [2:0] erm,
                                input logic [4:0] eacc);
        vec_t v;
        v.op = op; v.rm = rm; v.frm_v = fv; v.rd = rd;
        v.a = a; v.b = ~a; v.c = {a[15:0], a[31:16]}; v.res = res; v.fl = fl;
        v.hold = hold; v.clr = clr;
        v.exp_lat = elat; v.exp_ill = eill; v.exp_rm = erm; v.exp_acc = eacc;
        return v;
    endfunction

    // Reference rules: class latency by opcode range, DYN substitution, reserved modes.
    function automatic vec_t ref_vec(input logic [4:0] op, input logic [2:0] rm, input logic [2:0] fv,
                                     input logic [4:0] rd, input logic [31:0] a, input logic [31:0] res,
                                     input logic [4:0] fl, input int hold, input logic clr,
                                     input logic [4:0] acc_in);
        int lat;
        int eff;
        logic ill;
        eff = (rm == 3'd7) ? int'(fv) : int'(rm);
        ill = (eff >= 5);
        if (op < 2)       lat = 2;
        else if (op == 2) lat = 3;
        else if (op == 3) lat = 10;
        else if (op == 4) lat = 12;
        else if (op < 9)  lat = 4;
        else              lat = 1;
        return mk(op, rm, fv, rd, a, res, fl, hold, clr, ill ? 0 : lat, ill, 3'(eff),
                  (clr ? 5'd0 : acc_in) | (ill ? 5'd0 : fl));
    endfunction

    task automatic chk_alu_regs(input string tag);
        chk({tag, "_alu_a"}, alu_a, m_a);
        chk({tag, "_alu_b"}, alu_b, m_b);
        chk({tag, "_alu_c"}, alu_c, m_c);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'(m_ctrl));
        chk({tag, "_alu_rm"}, 32'(alu_rm), 32'(m_rm));
    endtask

    // Called at a falling edge with the DUT idle; ends at a falling edge with it idle again.
    task automatic run_op(input vec_t v);
        logic [31:0] e_res;
        logic [4:0]  e_fl;
        tb_lat = v.exp_ill ? 0 : v.exp_lat;
        good_res = v.res; good_fl = v.fl;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = v.op; req_rm = v.rm; frm = v.frm_v; req_rd = v.rd;
        req_a = v.a; req_b = v.b; req_c = v.c;
        @(negedge clk);
        req_valid = 1'b0;
        if (!v.exp_ill) begin
            m_a = v.a; m_b = v.b; m_c = v.c; m_ctrl = v.op; m_rm = v.exp_rm;
            for (int i = 0; i < v.exp_lat; i++) begin
                chk("exec_alu_enable", 32'(alu_enable), 32'd1);
                chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("exec_req_ready", 32'(req_ready), 32'd0);
                if (i == 0 || i == v.exp_lat - 1) chk_alu_regs("exec");
                @(negedge clk);
            end
        end
        e_res = v.exp_ill ? 32'd0 : v.res;
        e_fl  = v.exp_ill ? 5'd0 : v.fl;
        for (int w = 0; w <= v.hold; w++) begin
            chk("done_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("done_alu_enable", 32'(alu_enable), 32'd0);
            chk("done_busy", 32'(busy), 32'd1);
            chk("done_rsp_result", rsp_result, e_res);
            chk("done_rsp_fflags", 32'(rsp_fflags), 32'(e_fl));
            chk("done_rsp_rd", 32'(rsp_rd), 32'(v.rd));
            chk("done_rsp_illegal", 32'(rsp_illegal), 32'(v.exp_ill));
            if (w == 0) chk_alu_regs("done");
            if (w == v.hold) begin
                rsp_ready = 1'b1;
                fflags_clr = v.clr;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0; fflags_clr = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_fflags_acc", 32'(fflags_acc), 32'(v.exp_acc));
        acc_model = v.exp_acc;
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_alu_enable", 32'(alu_enable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
        chk("rst_rsp_fflags", 32'(rsp_fflags), 32'd0);
        chk("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
        chk("rst_fflags_acc", 32'(fflags_acc), 32'd0);
        m_a = '0; m_b = '0; m_c = '0; m_ctrl = '0; m_rm = '0;
        chk_alu_regs("rst");
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = mk(5'd0,  3'd0, 3'd0, 5'd3,  32'h3F800000, 32'h40400000, 5'b00000, 0, 1'b0, 2,  1'b0, 3'd0, 5'b00000);
        tbl[1]  = mk(5'd3,  3'd7, 3'd1, 5'd5,  32'h41200000, 32'h3EAAAAAB, 5'b01000, 0, 1'b0, 10, 1'b0, 3'd1, 5'b01000);
        tbl[2]  = mk(5'd1,  3'd7, 3'd6, 5'd7,  32'h12345678, 32'hCAFEF00D, 5'b10101, 0, 1'b0, 0,  1'b1, 3'd0, 5'b01000);
        tbl[3]  = mk(5'd2,  3'd3, 3'd0, 5'd9,  32'hC0000000, 32'h7F7FFFFF, 5'b00100, 1, 1'b0, 3,  1'b0, 3'd3, 5'b01100);
        tbl[4]  = mk(5'd6,  3'd4, 3'd2, 5'd11, 32'h00800000, 32'h00000001, 5'b00010, 0, 1'b0, 4,  1'b0, 3'd4, 5'b01110);
        tbl[5]  = mk(5'd20, 3'd2, 3'd0, 5'd13, 32'h7FC00000, 32'h00000000, 5'b10000, 2, 1'b1, 1,  1'b0, 3'd2, 5'b10000);
        tbl[6]  = mk(5'd1,  3'd0, 3'd3, 5'd15, 32'h3DCCCCCD, 32'h3E4CCCCD, 5'b00001, 7, 1'b1, 2,  1'b0, 3'd0, 5'b00001);
        tbl[7]  = mk(5'd4,  3'd5, 3'd0, 5'd17, 32'h40800000, 32'h40000000, 5'b11111, 0, 1'b0, 0,  1'b1, 3'd0, 5'b00001);
        tbl[8]  = mk(5'd4,  3'd7, 3'd4, 5'd19, 32'h40000000, 32'h3FB504F3, 5'b00011, 0, 1'b0, 12, 1'b0, 3'd4, 5'b00011);
        tbl[9]  = mk(5'd8,  3'd7, 3'd0, 5'd21, 32'hBF800000, 32'h41000000, 5'b00000, 0, 1'b0, 4,  1'b0, 3'd0, 5'b00011);
        tbl[10] = mk(5'd9,  3'd1, 3'd5, 5'd23, 32'h80000000, 32'h00000010, 5'b00100, 0, 1'b0, 1,  1'b0, 3'd1, 5'b00111);
        tbl[11] = mk(5'd5,  3'd7, 3'd7, 5'd25, 32'h3F000000, 32'hFFFFFFFF, 5'b11000, 0, 1'b0, 0,  1'b1, 3'd0, 5'b00111);

        repeat (2) @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        #1 chk("req_ready_after_reset", 32'(req_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_op(tbl[i]);

        // Flush during the fifth FSQRT execute cycle.
        tb_lat = 12; good_res = 32'h11111111; good_fl = 5'b11111;
        req_valid = 1'b1; req_op = 5'd4; req_rm = 3'd0; req_rd = 5'd2;
        req_a = 32'hA0A0A0A0; req_b = 32'hB0B0B0B0; req_c = 32'hC0C0C0C0;
        @(negedge clk);
        req_valid = 1'b0;
        m_a = 32'hA0A0A0A0; m_b = 32'hB0B0B0B0; m_c = 32'hC0C0C0C0; m_ctrl = 5'd4; m_rm = 3'd0;
        repeat (4) @(negedge clk);
        chk("flush_pre_enable", 32'(alu_enable), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_alu_enable", 32'(alu_enable), 32'd0);
        chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("flush_req_ready", 32'(req_ready), 32'd1);
        chk("flush_acc", 32'(fflags_acc), 32'(acc_model));
        @(negedge clk);
        chk("flush_rsp_valid_later", 32'(rsp_valid), 32'd0);
        run_op(mk(5'd2, 3'd1, 3'd0, 5'd30, 32'h40400000, 32'h41100000, 5'b00000, 0, 1'b0, 3, 1'b0, 3'd1, acc_model));

        // Flush beats a simultaneous accept.
        req_valid = 1'b1; flush = 1'b1; req_op = 5'd0; req_rm = 3'd0; req_a = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_busy", 32'(busy), 32'd0);
        chk("flush_accept_enable", 32'(alu_enable), 32'd0);
        chk_alu_regs("flush_accept");

        // Flush beats a simultaneous response handshake.
        tb_lat = 1; good_res = 32'h55AA55AA; good_fl = 5'b10000;
        req_valid = 1'b1; req_op = 5'd10; req_rm = 3'd0; req_rd = 5'd4;
        req_a = 32'h1; req_b = 32'h2; req_c = 32'h3;
        @(negedge clk);
        req_valid = 1'b0;
        m_a = 32'h1; m_b = 32'h2; m_c = 32'h3; m_ctrl = 5'd10; m_rm = 3'd0;
        @(negedge clk);
        chk("fhs_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("fhs_rsp_fflags", 32'(rsp_fflags), 32'(5'b10000));
        rsp_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; flush = 1'b0;
        chk("fhs_rsp_valid_after", 32'(rsp_valid), 32'd0);
        chk("fhs_busy", 32'(busy), 32'd0);
        chk("fhs_acc", 32'(fflags_acc), 32'(acc_model));

        // Reset in the middle of an FMA.
        tb_lat = 4; good_res = 32'h0; good_fl = 5'b0;
        req_valid = 1'b1; req_op = 5'd5; req_rm = 3'd0; req_rd = 5'd6;
        req_a = 32'hF00DF00D; req_b = 32'h1234ABCD; req_c = 32'h0BADCAFE;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_enable", 32'(alu_enable), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        acc_model = '0;
        #1 chk("rstmid_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            vec_t v;
            v = ref_vec(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                        5'($urandom_range(0, 31)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc_model);
            run_op(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/fp_issue_sequencer.md
# fp_issue_sequencer

Sequences single-precision operations into the shared FP ALU (RV32F datapath) for the core's FP issue path. It accepts one operation at a time from decode over a valid/ready handshake and resolves the dynamic rounding mode against `frm`. It asserts the ALU `enable` only for the operation's latency window, captures the result and exception flags, and returns them to writeback over a second handshake. It also keeps a sticky `fflags` accumulator for the fcsr.

## Interface
Parameters (each must be ≥1):
- LAT_ADD, 2, cycles for FADD/FSUB
- LAT_MUL, 3, cycles for FMUL
- LAT_FMA, 4, cycles for the four fused ops
- LAT_DIV, 10, cycles for FDIV
- LAT_SQRT, 12, cycles for FSQRT
- LAT_MISC, 1, cycles for compare/convert/sign-inject/move/classify

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  / req_ready  out  1  issue handshake
- req_op  in  5  ALU control code; req_rm  in  3  instruction rounding mode; req_rd  in  5  destination tag
- req_a, req_b, req_c  in  32  operands
- frm  in  3  dynamic rounding mode from fcsr
- flush  in  1  pipeline kill
- alu_a, alu_b, alu_c  out  32; alu_ctrl  out  5; alu_rm  out  3; alu_enable  out  1  FP ALU drive
- alu_result  in  32; alu_fflags  in  5  FP ALU outputs
- rsp_valid  out  1 / rsp_ready  in  1  writeback handshake
- rsp_result  out  32; rsp_rd  out  5; rsp_fflags  out  5 {NV,DZ,OF,UF,NX}; rsp_illegal  out  1
- fflags_acc  out  5 sticky flags; fflags_clr  in  1  clear accumulator
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, EXEC, DONE.
- req_ready = (state==IDLE) && !reset. Accept occurs when req_valid && req_ready && !flush.
- On accept, the rounding mode resolves as:
  - eff_rm = (req_rm==3'b111) ? frm : req_rm.
  - eff_rm in {101,110,111} is illegal.
- On a legal accept:
  - Register req_op/eff_rm/a/b/c into the alu_* outputs and req_rd into rsp_rd.
  - Load the counter with op_latency(req_op)−1.
  - Go to EXEC.
- On an illegal accept:
  - alu_* registers are not updated.
  - rsp_result=0, rsp_fflags=0, rsp_illegal=1, rsp_rd=req_rd.
  - Go to DONE.
- Op class by req_op:
  - 0–1 ADD
  - 2 MUL
  - 3 DIV
  - 4 SQRT
  - 5–8 FMA
  - 9–31 MISC
- EXEC:
  - alu_enable=1.
  - The counter decrements each cycle.
  - When the counter is 0, capture alu_result→rsp_result and alu_fflags→rsp_fflags, set rsp_illegal=0, and go to DONE.
- DONE:
  - rsp_valid=1. All rsp_* fields are held stable until rsp_ready.
  - On handshake, go to IDLE.
  - No new accept occurs in the handshake cycle.
- alu_a/b/c/ctrl/rm hold their values outside accept cycles, so the ALU inputs do not toggle while the block is idle.
- Flush in any state:
  - Next state is IDLE and alu_enable drops next cycle.
  - Any pending response is discarded with no accumulation.
  - Flush beats a simultaneous accept, and it beats a simultaneous rsp handshake: the handshake is not counted.
- Accumulator update: fflags_acc ← (fflags_clr ? 0 : fflags_acc) | (rsp handshake ? rsp_fflags : 0). Flags arriving in the clear cycle survive.

## Timing
- Reset values:
  - state=IDLE, busy=0.
  - alu_enable=0, alu_a/b/c=0, alu_ctrl=0, alu_rm=0.
  - rsp_valid=0, rsp_result=0, rsp_rd=0, rsp_fflags=0, rsp_illegal=0.
  - fflags_acc=0.
  - req_ready=0 during the reset cycle.
- Reset mid-operation aborts exactly like flush and also clears the accumulator.
- Legal op accepted in cycle N:
  - alu_enable high in cycles N+1 … N+LAT.
  - Capture at the end of cycle N+LAT.
  - rsp_valid from N+LAT+1.
- Illegal op accepted in cycle N: rsp_valid from N+1; alu_enable is never asserted.
- Throughput with rsp_ready tied high: one op per LAT+2 cycles. Response handshake in cycle M gives req_ready at M+1.
- alu_enable is a registered output and is never high in IDLE or DONE.

## Structure
- Package `fp_issue_pkg` holds:
  - The state enum.
  - Op code localparams (FP_ADD=0 … FP_FNMADD=8).
  - Rounding mode localparams (RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111).
  - Function `op_latency(op)` taking the LAT_* values.
- The counter is 4 bits wide, which is sufficient for LAT≤16. Parameters above 16 are rejected at elaboration.
- One natural sub-module is `fp_rm_resolve`, a combinational block that computes eff_rm and the illegal flag. Everything else stays in the top block.

## Test plan
- FADD with req_rm=000, request in cycle 0 -> alu_enable high in cycles 1–2, ALU result 0x40400000/fflags 0 captured, rsp_valid in cycle 3, req_ready back in the cycle after handshake.
- FDIV with req_rm=111, frm=001, ALU returning fflags 01000 -> alu_rm=001, 10 enable cycles, rsp_fflags=01000, fflags_acc=01000 after handshake.
- req_rm=111 with frm=110 -> rsp_illegal=1 and rsp_valid in cycle 1, alu_enable never high, fflags_acc unchanged.
- FSQRT with flush in EXEC cycle 5 -> IDLE next cycle, alu_enable low, no rsp_valid, accumulator unchanged; following FMUL completes with LAT=3.
- rsp_ready held low for 7 cycles with fflags NX -> rsp_* stable throughout; on handshake together with fflags_clr=1 and prior acc=10000 -> fflags_acc=00001.
- Reset asserted during FMA EXEC -> all outputs at reset values next cycle; req_ready=1 after reset deasserts.
